// File: rtl/cflog_slice_ctrl_if.sv
// Producer / TCB facing signals of the CF-Log slice scheduler.
// master: the scheduler itself; slave: the producer and TCB side.
interface cflog_slice_ctrl_if;
  logic        boot;
  logic        ER_done;
  logic        cflow_hw_wen;
  logic        flush_ack;
  logic [15:0] cflow_log_ptr;
  logic        flush_slice;
  logic [15:0] top_slice;
  logic [15:0] bottom_slice;
  logic        log_drained;
  logic        reset;

  modport master (
    input  boot, ER_done, cflow_hw_wen, flush_ack,
    output cflow_log_ptr, flush_slice, top_slice, bottom_slice, log_drained, reset
  );

  modport slave (
    output boot, ER_done, cflow_hw_wen, flush_ack,
    input  cflow_log_ptr, flush_slice, top_slice, bottom_slice, log_drained, reset
  );
endinterface

// File: rtl/cflog_slice_ctrl.sv
// Slice scheduler for the CF-Log ring buffer: tracks the write pointer, queues full slices, drives the flush handshake.
// Optional macro CFLOG_PARTIAL_FLUSH_EN: the trailing partial slice is also flushed when ER_done arrives.
module cflog_slice_ctrl #(
  parameter logic [15:0] LOG_BASE    = 16'h0600,
  parameter int          LOG_WORDS   = 256,
  parameter int          SLICE_WORDS = 64,
  localparam int         NUM_SLICES  = LOG_WORDS / SLICE_WORDS
) (
  input logic                clk,
  input logic                puc,
  cflog_slice_ctrl_if.master bus
);
  localparam int WB  = $clog2(LOG_WORDS);
  localparam int SWB = $clog2(SLICE_WORDS);
  localparam int SB  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef logic [WB-1:0] wr_t;
  typedef logic [SB-1:0] rs_t;
  typedef logic [SB:0]   pend_t;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam pend_t          PEND_FULL   = pend_t'(NUM_SLICES);
  localparam pend_t          PEND_ZERO   = pend_t'(1'b0);
  localparam pend_t          PEND_ONE    = pend_t'(1'b1);
  localparam logic [15:0]    SLICE_BYTES = 16'(2 * SLICE_WORDS);
  localparam logic [SWB-1:0] LAST_OFS    = {SWB{1'b1}};
  localparam logic [SWB-1:0] FIRST_OFS   = {SWB{1'b0}};

  state_t      state_r, state_s;
  wr_t         wr_r, wr_s;
  rs_t         rs_r, rs_s;
  pend_t       pend_r, pend_s;
  logic        flush_r, flush_s;
  logic [15:0] top_r, top_s;
  logic [15:0] bottom_r, bottom_s;
  logic        drained_r, drained_s;
  logic        viol_r, viol_s;
  logic        ack_s, complete_s, overflow_s, hold_s;

`ifdef CFLOG_PARTIAL_FLUSH_EN
  logic        part_q_r, part_q_s;
  logic        part_wait_r, part_wait_s;
  wr_t         wr_last_s;
`endif

  // Next state, queue bookkeeping and next values of every registered output
  always_comb begin
    state_s    = state_r;
    wr_s       = wr_r;
    rs_s       = rs_r;
    pend_s     = pend_r;
    drained_s  = 1'b0;
    viol_s     = 1'b0;
    hold_s     = 1'b0;
`ifdef CFLOG_PARTIAL_FLUSH_EN
    part_q_s    = part_q_r;
    part_wait_s = part_wait_r;
    wr_last_s   = wr_r;
`endif
    ack_s      = bus.flush_ack & flush_r;
    complete_s = bus.cflow_hw_wen & (wr_r[SWB-1:0] == LAST_OFS);
    overflow_s = bus.cflow_hw_wen & (pend_r == PEND_FULL);

    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.boot) begin
          state_s = S_RUN;
          wr_s    = wr_t'(1'b0);
          rs_s    = rs_t'(1'b0);
          pend_s  = PEND_ZERO;
`ifdef CFLOG_PARTIAL_FLUSH_EN
          part_q_s    = 1'b0;
          part_wait_s = 1'b0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (overflow_s) begin
          // The write lands in an unflushed slice: drop it, discard any ack, clear the queue
          viol_s  = 1'b1;
          state_s = S_IDLE;
          rs_s    = rs_t'(1'b0);
          pend_s  = PEND_ZERO;
        end else begin
          if (bus.cflow_hw_wen) begin
            wr_s = wr_r + wr_t'(1'b1);
          end else begin
            wr_s = wr_r;
          end
          if (ack_s) begin
            rs_s = rs_r + rs_t'(1'b1);
          end else begin
            rs_s = rs_r;
          end
          case ({complete_s, ack_s})
            2'b10:   pend_s = pend_r + PEND_ONE;
            2'b01:   pend_s = pend_r - PEND_ONE;
            default: pend_s = pend_r;
          endcase
          if (bus.ER_done) begin
            state_s = S_DRAIN;
`ifdef CFLOG_PARTIAL_FLUSH_EN
            if (wr_s[SWB-1:0] != FIRST_OFS) begin
              if (pend_s == PEND_FULL) begin
                part_wait_s = 1'b1;
              end else begin
                pend_s   = pend_s + PEND_ONE;
                part_q_s = 1'b1;
              end
            end else begin
              part_wait_s = 1'b0;
            end
`endif
          end else begin
            state_s = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (ack_s) begin
          rs_s   = rs_r + rs_t'(1'b1);
          pend_s = pend_r - PEND_ONE;
`ifdef CFLOG_PARTIAL_FLUSH_EN
          if (pend_r == PEND_ONE) begin
            part_q_s = 1'b0;
          end else begin
            part_q_s = part_q_r;
          end
`endif
        end else begin
          rs_s   = rs_r;
          pend_s = pend_r;
        end
`ifdef CFLOG_PARTIAL_FLUSH_EN
        if (part_wait_r && (pend_s != PEND_FULL)) begin
          pend_s      = pend_s + PEND_ONE;
          part_q_s    = 1'b1;
          part_wait_s = 1'b0;
        end else begin
          part_wait_s = part_wait_r;
        end
        hold_s = part_wait_s;
`endif
        if ((pend_s == PEND_ZERO) && !hold_s) begin
          drained_s = 1'b1;
          state_s   = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    flush_s  = (pend_s != PEND_ZERO) && ((state_s == S_RUN) || (state_s == S_DRAIN));
    top_s    = LOG_BASE + (16'(rs_s) * SLICE_BYTES);
    bottom_s = top_s + SLICE_BYTES - 16'd2;
`ifdef CFLOG_PARTIAL_FLUSH_EN
    // The partial entry is always the queue tail, so it is presented only once it is alone
    wr_last_s = wr_s - wr_t'(1'b1);
    if (part_q_s && (pend_s == PEND_ONE)) begin
      bottom_s = LOG_BASE + (16'(wr_last_s) * 16'd2);
    end else begin
      bottom_s = top_s + SLICE_BYTES - 16'd2;
    end
`endif
  end

  // State, pointers and registered outputs; puc overrides every other input
  always_ff @(posedge clk) begin
    if (puc) begin
      state_r   <= S_IDLE;
      wr_r      <= wr_t'(1'b0);
      rs_r      <= rs_t'(1'b0);
      pend_r    <= PEND_ZERO;
      flush_r   <= 1'b0;
      top_r     <= LOG_BASE;
      bottom_r  <= LOG_BASE + SLICE_BYTES - 16'd2;
      drained_r <= 1'b0;
      viol_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      wr_r      <= wr_s;
      rs_r      <= rs_s;
      pend_r    <= pend_s;
      flush_r   <= flush_s;
      top_r     <= top_s;
      bottom_r  <= bottom_s;
      drained_r <= drained_s;
      viol_r    <= viol_s;
    end
  end

`ifdef CFLOG_PARTIAL_FLUSH_EN
  // Partial-slice tracking: queued as tail entry, or waiting for a free queue position
  always_ff @(posedge clk) begin
    if (puc) begin
      part_q_r    <= 1'b0;
      part_wait_r <= 1'b0;
    end else begin
      part_q_r    <= part_q_s;
      part_wait_r <= part_wait_s;
    end
  end
`endif

  assign bus.cflow_log_ptr = 16'(wr_r);
  assign bus.flush_slice   = flush_r;
  assign bus.top_slice     = top_r;
  assign bus.bottom_slice  = bottom_r;
  assign bus.log_drained   = drained_r;
  assign bus.reset         = viol_r;
endmodule

// File: tb/tb_cflog_slice_ctrl.sv
// Self-checking bench for cflog_slice_ctrl: directed vector table, wrap sequence, and random traffic vs a queue model.
module tb_cflog_slice_ctrl;
  localparam logic [15:0] BASE = 16'h0600;
  localparam int LW = 256;
  localparam int SW = 64;
  localparam int NS = LW / SW;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic puc;
  always #5 clk = ~clk;

  cflog_slice_ctrl_if bus_if();
  cflog_slice_ctrl #(.LOG_BASE(BASE), .LOG_WORDS(LW), .SLICE_WORDS(SW)) dut (
    .clk(clk), .puc(puc), .bus(bus_if.master)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of slices, each described by its first and last word index
  typedef struct { int first; int last; } ent_t;
  ent_t mq[$];
  int   m_state = M_IDLE;
  int   m_wr = 0;
  bit   m_wait = 1'b0;
  ent_t m_wait_ent;
  bit   m_flush = 1'b0, m_drained = 1'b0, m_rst = 1'b0;

  function automatic ent_t partial_entry(input int wr);
    ent_t e;
    e.first = wr - (wr % SW);
    e.last  = (wr + LW - 1) % LW;
    return e;
  endfunction

  task automatic model_step(input bit p, input bit b, input bit er, input bit wen, input bit ack);
    bit ackv;
    ent_t e;
    ackv = ack && m_flush;
    m_drained = 1'b0;
    m_rst = 1'b0;
    if (p) begin
      m_state = M_IDLE; m_wr = 0; mq.delete(); m_wait = 1'b0;
    end else begin
      case (m_state)
        M_IDLE, M_DONE: if (b) begin
          m_wr = 0; mq.delete(); m_wait = 1'b0; m_state = M_RUN;
        end
        M_RUN: begin
          if (wen && mq.size() == NS) begin
            m_rst = 1'b1; m_state = M_IDLE; mq.delete();
          end else begin
            if (ackv) void'(mq.pop_front());
            if (wen) begin
              if (m_wr % SW == SW - 1) begin
                e.first = m_wr - SW + 1; e.last = m_wr;
                mq.push_back(e);
              end
              m_wr = (m_wr + 1) % LW;
            end
            if (er) begin
              m_state = M_DRAIN;
`ifdef CFLOG_PARTIAL_FLUSH_EN
              if (m_wr % SW != 0) begin
                if (mq.size() == NS) begin
                  m_wait = 1'b1; m_wait_ent = partial_entry(m_wr);
                end else begin
                  mq.push_back(partial_entry(m_wr));
                end
              end
`endif
            end
          end
        end
        M_DRAIN: begin
          if (ackv) void'(mq.pop_front());
          if (m_wait && mq.size() < NS) begin
            mq.push_back(m_wait_ent); m_wait = 1'b0;
          end
          if (mq.size() == 0 && !m_wait) begin
            m_drained = 1'b1; m_state = M_DONE;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
    m_flush = (mq.size() != 0) && (m_state == M_RUN || m_state == M_DRAIN);
  endtask

  task automatic cyc(input bit p, input bit b, input bit er, input bit wen, input bit ack);
    puc = p;
    bus_if.boot = b;
    bus_if.ER_done = er;
    bus_if.cflow_hw_wen = wen;
    bus_if.flush_ack = ack;
    @(posedge clk);
    model_step(p, b, er, wen, ack);
    #1;
    chk("model.ptr", bus_if.cflow_log_ptr, 16'(m_wr));
    chk("model.flush", 16'(bus_if.flush_slice), 16'(m_flush));
    chk("model.drained", 16'(bus_if.log_drained), 16'(m_drained));
    chk("model.reset", 16'(bus_if.reset), 16'(m_rst));
    if (m_flush) begin
      chk("model.top", bus_if.top_slice, BASE + 16'(2 * mq[0].first));
      chk("model.bottom", bus_if.bottom_slice, BASE + 16'(2 * mq[0].last));
    end
  endtask

  typedef struct {
    int n; bit p, b, er, wen, ack;
    logic [15:0] ptr; bit fl; logic [15:0] top, bot; bit dr, rs;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input bit p, input bit b, input bit er, input bit wen, input bit ack,
                     input logic [15:0] ptr, input bit fl, input logic [15:0] top, input logic [15:0] bot,
                     input bit dr, input bit rs);
    vec_t v;
    v.n = n; v.p = p; v.b = b; v.er = er; v.wen = wen; v.ack = ack;
    v.ptr = ptr; v.fl = fl; v.top = top; v.bot = bot; v.dr = dr; v.rs = rs;
    tbl.push_back(v);
  endtask

  initial begin
    //  n    p     b     er    wen   ack   ptr       fl    top       bottom    dr    rs
    add(2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(63,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h003F, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0680, 16'h06FE, 1'b0, 1'b0);
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(255, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b1);
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(64,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(63,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h007F, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0080, 1'b1, 16'h0680, 16'h06FE, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0080, 1'b0, 16'h0700, 16'h077E, 1'b0, 1'b0);
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(70,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0046, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0046, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
`ifdef CFLOG_PARTIAL_FLUSH_EN
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0046, 1'b1, 16'h0680, 16'h068A, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0046, 1'b0, 16'h0700, 16'h077E, 1'b1, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0046, 1'b0, 16'h0700, 16'h077E, 1'b0, 1'b0);
`else
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0046, 1'b0, 16'h0680, 16'h06FE, 1'b1, 1'b0);
    add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0046, 1'b0, 16'h0680, 16'h06FE, 1'b0, 1'b0);
`endif
    add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(64,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1, 16'h0600, 16'h067E, 1'b0, 1'b0);
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0600, 16'h067E, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc(tbl[i].p, tbl[i].b, tbl[i].er, tbl[i].wen, tbl[i].ack);
      chk($sformatf("v%0d.ptr", i), bus_if.cflow_log_ptr, tbl[i].ptr);
      chk($sformatf("v%0d.flush", i), 16'(bus_if.flush_slice), 16'(tbl[i].fl));
      chk($sformatf("v%0d.top", i), bus_if.top_slice, tbl[i].top);
      chk($sformatf("v%0d.bottom", i), bus_if.bottom_slice, tbl[i].bot);
      chk($sformatf("v%0d.drained", i), 16'(bus_if.log_drained), 16'(tbl[i].dr));
      chk($sformatf("v%0d.reset", i), 16'(bus_if.reset), 16'(tbl[i].rs));
    end

    // Wrap: five slices, each acked once presented; the fifth reuses the first slice address
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      repeat (SW) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("wrap%0d.flush", s), 16'(bus_if.flush_slice), 16'd1);
      chk($sformatf("wrap%0d.top", s), bus_if.top_slice, 16'h0600 + 16'((s % NS) * 128));
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("wrap.ptr", bus_if.cflow_log_ptr, 16'h0040);

    // Random traffic, slow then fast acks, checked every cycle by the model
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 3000; k++) begin
        cyc($urandom_range(0, 1999) == 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 399) == 0,
            $urandom_range(0, 9) < 6,
            (ph == 0) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) < 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cflog_slice_ctrl.md
# cflog_slice_ctrl

Slice scheduler for the control-flow log (CF-Log) ring buffer in the attestation hardware. It tracks the `cflow` write pointer across a fixed RAM region divided into equal slices, queues each filled slice for transmission, and drives the `flush_slice` / `top_slice` / `bottom_slice` request to the TCB with a level/ack handshake. It raises a one-cycle violation reset when the writer would overwrite a slice that has not yet been flushed. It sits between `cflow` (producer) and the reset/flush outputs of `acfa`.

## Interface
Parameters:
- `LOG_BASE`, 16'h0600: byte address of log word 0.
- `LOG_WORDS`, 256: log size in 16-bit words; must be a power of two.
- `SLICE_WORDS`, 64: words per slice; power of two; must divide `LOG_WORDS`.
- `NUM_SLICES`, `LOG_WORDS/SLICE_WORDS`: derived; not overridden.

Ports:
- `clk`  in  1  system clock.
- `puc`  in  1  reset. Synchronous, active-high.
- `boot`  in  1  pulse that starts a logging session.
- `ER_done`  in  1  pulse marking the end of the attested region.
- `cflow_hw_wen`  in  1  one log word is written this cycle.
- `flush_ack`  in  1  TCB pulse: the slice currently presented has been consumed.
- `cflow_log_ptr`  out  16  word index of the next write; range 0..`LOG_WORDS`-1.
- `flush_slice`  out  1  flush request; held high until acked.
- `top_slice`  out  16  byte address of the first word of the presented slice.
- `bottom_slice`  out  16  byte address of the last valid word of the presented slice (inclusive).
- `log_drained`  out  1  one-cycle pulse: session ended and every queued slice has been acked.
- `reset`  out  1  one-cycle overflow violation pulse.

## Operation
State machine: IDLE, RUN, DRAIN, DONE.
- **IDLE** (after `puc`):
  - `cflow_hw_wen` is ignored.
  - `boot` clears all pointers and counters, then goes to RUN.
- **RUN**:
  - On each `cflow_hw_wen`, the write index `wr` advances: `wr = (wr+1) mod LOG_WORDS`.
  - The write that fills the last word of a slice enqueues that slice: `pend` increments.
  - `ER_done` goes to DRAIN.
- **DRAIN**:
  - Writes are ignored.
  - A partial slice is handled per the Configuration section.
  - When `pend==0`, `log_drained` pulses and the FSM goes to DONE.
- **DONE**: holds until `boot`, which re-initialises everything and goes to RUN.

Queue:
- Slices complete in order. The read slice index `rs` (0..`NUM_SLICES`-1) plus `pend` (0..`NUM_SLICES`) fully describe the queue.
- `flush_slice = (pend != 0)` in the RUN and DRAIN states.
- `top_slice = LOG_BASE + 2*rs*SLICE_WORDS`.
- `bottom_slice = top_slice + 2*(SLICE_WORDS-1)`, except for the partial entry.
- All address math is 16-bit and truncating.

Handshake:
- `flush_ack` while `flush_slice` is high: `rs` advances mod `NUM_SLICES` and `pend` decrements.
- `flush_ack` while `flush_slice` is low is ignored.
- Slice completion and ack in the same cycle: `pend` is unchanged and `rs` advances.

Overflow:
- Condition: a `cflow_hw_wen` arrives with `pend==NUM_SLICES`, i.e. the write would land in an unflushed slice.
- Response: the write is dropped, `wr` is not advanced, `reset` pulses for 1 cycle, and the FSM goes to IDLE with the queue cleared.
- An ack in the same cycle does not rescue the write. Overflow is evaluated on the pre-edge `pend`.

`puc` in any state overrides every other input.

## Timing
- Reset values: `cflow_log_ptr`=0, `flush_slice`=0, `top_slice`=`LOG_BASE`, `bottom_slice`=`LOG_BASE`+2*(`SLICE_WORDS`-1), `log_drained`=0, `reset`=0, state=IDLE.
- `cflow_hw_wen` in cycle n: `cflow_log_ptr` updates at the edge ending cycle n.
- Slice-completing write in cycle n: `flush_slice` is high in cycle n+1.
- `flush_ack` in cycle n: the next slice (or `flush_slice`=0) is visible in cycle n+1.
- `top_slice` and `bottom_slice` are registered and stable whenever `flush_slice` is high.
- `log_drained` and `reset` are registered single-cycle pulses.
- Wrap: `wr` goes from `LOG_WORDS`-1 to 0; `rs` goes from `NUM_SLICES`-1 to 0.

## Configuration
Macro: `CFLOG_PARTIAL_FLUSH_EN`.
- **Defined**:
  - On `ER_done`, a non-empty current slice (fill>0) is enqueued as a partial entry, with `bottom_slice = LOG_BASE + 2*(wr-1)` (`wr-1` taken mod `LOG_WORDS`).
  - If `pend==NUM_SLICES` at `ER_done`, the partial entry waits until one ack frees a queue position, then is enqueued.
  - DRAIN completes after the partial entry is acked.
- **Not defined**:
  - Partial contents are discarded.
  - DRAIN flushes only the full slices; `bottom_slice` is always full-slice.

## Test plan
- Boot, then 64 writes with no ack → `flush_slice`=1 in the cycle after write 64, `top_slice`=16'h0600, `bottom_slice`=16'h067E; ack → `flush_slice`=0 next cycle.
- 256 writes without ack, then a 257th write → `reset` pulses 1 cycle, state IDLE, `cflow_log_ptr`=0; then `boot` plus writes resume normally.
- Wrap test: 320 writes with an ack after each slice → `cflow_log_ptr`=64 and the fifth slice presented has `top_slice`=16'h0600.
- Write #128 completes slice 1 in the same cycle as the ack for slice 0 → `pend` stays 1, `top_slice`=16'h0680.
- With `CFLOG_PARTIAL_FLUSH_EN`: 70 writes then `ER_done` → slice 0 full, then partial `top_slice`=16'h0680, `bottom_slice`=16'h068A; `log_drained` pulses one cycle after the second ack.
- Without the macro, same stimulus → only slice 0 is flushed; `log_drained` pulses one cycle after the first ack. `puc` mid-DRAIN → all outputs return to reset values next cycle.
